// File: rtl/cmd_queue_pkg.sv
// Shared robot constants and types for the command queue between UART_wrapper and cmd_proc.
package cmd_queue_pkg;

  localparam int CMD_W     = 16;
  localparam int CMD_DEPTH = 4;

  typedef logic [CMD_W-1:0] cmd_t;

  // What the queue does at one clock edge (flush and reset handled separately).
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_t;

endpackage

// File: rtl/cmd_queue_if.sv
// Handshake bundle: wrapper-side command intake, cmd_proc-side head delivery, flush and status.
interface cmd_queue_if
  import cmd_queue_pkg::*;
#(
  parameter int DEPTH = CMD_DEPTH
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  cmd_t             cmd_in;
  logic             cmd_in_rdy;
  logic             clr_in;
  cmd_t             cmd;
  logic             cmd_rdy;
  logic             clr_cmd_rdy;
  logic             flush;
  logic             full;
  logic [CNT_W-1:0] cnt;

  modport master (
    output cmd_in, cmd_in_rdy, clr_cmd_rdy, flush,
    input  clr_in, cmd, cmd_rdy, full, cnt
  );

  modport slave (
    input  cmd_in, cmd_in_rdy, clr_cmd_rdy, flush,
    output clr_in, cmd, cmd_rdy, full, cnt
  );

endinterface

// File: rtl/cmd_queue.sv
// Small FIFO of UART commands; acks each captured word with a one-cycle clr_in pulse.
module cmd_queue
  import cmd_queue_pkg::*;
#(
  parameter int DEPTH = CMD_DEPTH
) (
  input  logic           clk,
  input  logic           rst_n,
  cmd_queue_if.slave     bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] cnt;
  logic             clr_in;
  logic             cmd_rdy;
  logic             full;
  logic             push;
  logic             pop;
  op_t              op;

  assign cmd_rdy = (cnt != '0);
  assign full    = (cnt == CNT_W'(DEPTH));

  // clr_in high means the wrapper still shows the word just taken; ignore it.
  assign push = bus.cmd_in_rdy & ~clr_in & ~full & ~bus.flush;
  assign pop  = bus.clr_cmd_rdy & cmd_rdy & ~bus.flush;

  always_comb begin
    op = OP_IDLE;
    unique case ({push, pop})
      2'b10:   op = OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = OP_BOTH;
      default: op = OP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head   <= '0;
      tail   <= '0;
      cnt    <= '0;
      clr_in <= 1'b0;
    end else begin
      // A word pending at flush time is dropped but still acknowledged.
      clr_in <= push | (bus.flush & bus.cmd_in_rdy & ~clr_in);
      if (bus.flush) begin
        head <= '0;
        tail <= '0;
        cnt  <= '0;
      end else begin
        if (push) tail <= tail + PTR_W'(1);
        if (pop)  head <= head + PTR_W'(1);
        unique case (op)
          OP_PUSH: cnt <= cnt + CNT_W'(1);
          OP_POP:  cnt <= cnt - CNT_W'(1);
          default: cnt <= cnt;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) mem[tail] <= bus.cmd_in;
  end

  assign bus.cmd     = mem[head];
  assign bus.cmd_rdy = cmd_rdy;
  assign bus.full    = full;
  assign bus.cnt     = cnt;
  assign bus.clr_in  = clr_in;

endmodule

// File: tb/tb_cmd_queue.sv
// Directed scenarios plus randomized traffic, all checked against a queue-based reference model.
module tb_cmd_queue;

  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;

  cmd_queue_if #(.DEPTH(DEPTH)) bus();

  cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic [15:0] mq[$];
  logic        mclr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".cnt"},     32'(bus.cnt),     32'(mq.size()));
    chk({tag, ".cmd_rdy"}, 32'(bus.cmd_rdy), 32'(mq.size() != 0));
    chk({tag, ".full"},    32'(bus.full),    32'(mq.size() == DEPTH));
    chk({tag, ".clr_in"},  32'(bus.clr_in),  32'(mclr));
    if (mq.size() != 0) chk({tag, ".cmd"}, 32'(bus.cmd), 32'(mq[0]));
  endtask

  // One clock: drive inputs, advance the model by the queue's rules, compare after the edge.
  task automatic step(input string tag, input logic rdy, input logic [15:0] word,
                      input logic pop_req, input logic fl, input logic rst);
    logic do_push;
    logic do_pop;
    logic nclr;
    @(negedge clk);
    bus.cmd_in_rdy  = rdy;
    bus.cmd_in      = word;
    bus.clr_cmd_rdy = pop_req;
    bus.flush       = fl;
    rst_n           = rst;
    if (!rst) begin
      mq.delete();
      mclr = 1'b0;
    end else begin
      do_push = rdy && !mclr && (mq.size() < DEPTH) && !fl;
      do_pop  = pop_req && (mq.size() != 0) && !fl;
      nclr    = do_push || (fl && rdy && !mclr);
      if (fl) mq.delete();
      else begin
        if (do_pop)  void'(mq.pop_front());
        if (do_push) mq.push_back(word);
      end
      mclr = nclr;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Wrapper-style send: hold the word through the capture edge and the clr_in cycle.
  task automatic send(input logic [15:0] w);
    step("send", 1'b1, w, 1'b0, 1'b0, 1'b1);
    step("send_ack", 1'b1, w, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic pop1(input string tag);
    step(tag, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    logic        have;
    logic [15:0] word;
    logic        clr_before;
    logic        rnd_pop;
    logic        rnd_fl;
    logic        rnd_rst;

    bus.cmd_in      = '0;
    bus.cmd_in_rdy  = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    bus.flush       = 1'b0;
    rst_n           = 1'b0;

    step("reset", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    step("reset", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("reset.cnt_zero", 32'(bus.cnt), 32'd0);

    // Single command, single ack.
    step("first_push", 1'b1, 16'h2000, 1'b0, 1'b0, 1'b1);
    chk("first_push.clr_in", 32'(bus.clr_in), 32'd1);
    chk("first_push.cmd", 32'(bus.cmd), 32'h2000);
    step("first_ack", 1'b1, 16'h2000, 1'b0, 1'b0, 1'b1);
    chk("first_ack.no_double", 32'(bus.cnt), 32'd1);
    idle("first_idle");
    pop1("first_pop");

    // FIFO order.
    send(16'h4001);
    send(16'h4002);
    send(16'h4003);
    chk("order.head0", 32'(bus.cmd), 32'h4001);
    pop1("order.pop1");
    chk("order.head1", 32'(bus.cmd), 32'h4002);
    pop1("order.pop2");
    chk("order.head2", 32'(bus.cmd), 32'h4003);
    pop1("order.pop3");
    chk("order.empty", 32'(bus.cmd_rdy), 32'd0);
    pop1("order.pop_empty");

    // Full back-pressure; a pop frees the slot for the following cycle.
    send(16'h6001);
    send(16'h6002);
    send(16'h6003);
    send(16'h6004);
    chk("full.set", 32'(bus.full), 32'd1);
    step("full.blocked", 1'b1, 16'h6005, 1'b0, 1'b0, 1'b1);
    step("full.blocked", 1'b1, 16'h6005, 1'b0, 1'b0, 1'b1);
    chk("full.no_ack", 32'(bus.clr_in), 32'd0);
    step("full.pop", 1'b1, 16'h6005, 1'b1, 1'b0, 1'b1);
    chk("full.pop_no_ack", 32'(bus.clr_in), 32'd0);
    step("full.late_push", 1'b1, 16'h6005, 1'b0, 1'b0, 1'b1);
    chk("full.late_ack", 32'(bus.clr_in), 32'd1);
    chk("full.cnt4", 32'(bus.cnt), 32'd4);
    step("full.ack", 1'b1, 16'h6005, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) pop1("full.drain");

    // Simultaneous push and pop at cnt=2.
    send(16'h1111);
    send(16'h2222);
    step("both", 1'b1, 16'h5555, 1'b1, 1'b0, 1'b1);
    chk("both.cnt2", 32'(bus.cnt), 32'd2);
    step("both.ack", 1'b1, 16'h5555, 1'b0, 1'b0, 1'b1);
    chk("both.head", 32'(bus.cmd), 32'h2222);
    pop1("both.pop1");
    chk("both.tail", 32'(bus.cmd), 32'h5555);
    pop1("both.pop2");

    // Flush with a pending command.
    send(16'h7001);
    send(16'h7002);
    send(16'h7003);
    step("flush", 1'b1, 16'h7777, 1'b0, 1'b1, 1'b1);
    chk("flush.ack", 32'(bus.clr_in), 32'd1);
    step("flush.ack_cycle", 1'b1, 16'h7777, 1'b0, 1'b0, 1'b1);
    idle("flush.idle");
    chk("flush.dropped", 32'(bus.cmd_rdy), 32'd0);

    // Reset mid-stream with a push about to happen.
    send(16'h8001);
    send(16'h8002);
    send(16'h8003);
    step("midrst", 1'b1, 16'h8004, 1'b0, 1'b0, 1'b0);
    step("post_rst", 1'b1, 16'h2000, 1'b0, 1'b0, 1'b1);
    chk("post_rst.cmd", 32'(bus.cmd), 32'h2000);
    step("post_rst.ack", 1'b1, 16'h2000, 1'b0, 1'b0, 1'b1);
    pop1("post_rst.pop");

    // Randomized traffic from a wrapper that holds each word until its ack cycle ends.
    have = 1'b0;
    word = '0;
    for (int i = 0; i < 600; i++) begin
      if (!have && ($urandom % 3 == 0)) begin
        have = 1'b1;
        word = 16'($urandom);
      end
      rnd_pop    = ($urandom % 5) < 2;
      rnd_fl     = ($urandom % 40) == 0;
      rnd_rst    = ($urandom % 97) != 0;
      clr_before = mclr;
      step("rand", have, word, rnd_pop, rnd_fl, rnd_rst);
      if (clr_before) have = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
